gesture_cmd_uart_tx: RTL

Transmit side of the finger-count path. Takes the debounced stable_count and sends it to the arm controller as a 3-byte command frame over a UART link (8N1, LSB first, idle high). A frame is sent on every change of the count, and optionally as a periodic refresh. Sits between the count stabilizer output and the FPGA TX pin that drives the servo controller board.

---
 rtl/gesture_cmd_uart_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gesture_cmd_uart_tx.sv
// gesture_cmd_uart_tx
// Sends the stabilized finger count to the arm controller as a 3-byte UART
// frame {HEADER, {seq, 0, count}, checksum}. The line format is 8N1, LSB first, idle high.
// A frame starts when the count changes, and optionally on a periodic refresh.
module gesture_cmd_uart_tx #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned REFRESH_CYCLES = 0,
    parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] stable_count,
    input  logic       tx_enable,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] seq_num
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Refresh counter is wide enough for REFRESH_CYCLES-1 and never zero-width
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES + 2);
    localparam int unsigned REF_LAST_INT = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_LAST_INT);
    localparam bit REFRESH_ON = (REFRESH_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_byte1;
    logic [2:0]       r_last_sent;
    logic [3:0]       r_seq;
    logic [REF_W-1:0] r_ref_cnt;
    logic             r_tx;
    logic             r_busy;
    logic             r_frame_done;
    logic [3:0]       r_seq_num;

    logic             w_bit_end;
    logic             w_ref_expire;
    logic             w_launch;
    logic [7:0]       w_cur_byte;
    logic             w_next_bit;

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign seq_num    = r_seq_num;

    assign w_bit_end    = (r_clk_cnt == BIT_LAST);
    assign w_ref_expire = REFRESH_ON && (r_ref_cnt == REF_LAST);
    // A change and a refresh expiry in the same cycle still yield a single launch
    assign w_launch     = (r_state == S_IDLE) && tx_enable &&
                          ((stable_count != r_last_sent) || w_ref_expire);
    assign w_next_bit   = w_cur_byte[r_bit_idx + 3'd1];

    // Select the byte being shifted out; byte 2 is the XOR checksum of bytes 0 and 1
    always_comb begin
        w_cur_byte = HEADER_BYTE;
        case (r_byte_idx)
            2'd0:    w_cur_byte = HEADER_BYTE;
            2'd1:    w_cur_byte = r_byte1;
            default: w_cur_byte = HEADER_BYTE ^ r_byte1;
        endcase
    end

    // Idle refresh timer: counts idle cycles while enabled, clears otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt <= '0;
        end else if (w_launch || !tx_enable || (r_state != S_IDLE)) begin
            r_ref_cnt <= '0;
        end else begin
            r_ref_cnt <= r_ref_cnt + REF_W'(1);
        end
    end

    // Frame FSM: launch, start/data/stop per byte, then one bit time of guard gap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_byte1      <= '0;
            r_last_sent  <= '0;
            r_seq        <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_seq_num    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_launch) begin
                        r_byte1     <= {r_seq, 1'b0, stable_count};
                        r_last_sent <= stable_count;
                        r_seq_num   <= r_seq;
                        r_seq       <= r_seq + 4'd1;
                        r_byte_idx  <= '0;
                        r_bit_idx   <= '0;
                        r_clk_cnt   <= '0;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_next_bit;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == 2'd2) begin
                            r_tx         <= 1'b1;
                            r_frame_done <= 1'b1;
                            r_state      <= S_GAP;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
